brc_seq: RTL and testbench

Parametrised, multi-cycle branch comparator for the RISC-V core. It compares two XLEN-bit register operands one CHUNK-bit slice per cycle, most-significant slice first, and produces less, equal and a decoded branch-taken flag. It sits between operand read and the PC-select logic of the multi-cycle core variant, and talks to both sides over valid/ready handshakes.

---
 rtl/brc_pkg.sv | 28 ++
 rtl/brc_slice_cmp.sv | 26 ++
 rtl/brc_seq.sv | 129 ++++++++++++
 tb/tb_brc_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types and helpers for the slice-serial branch comparator.
package brc_pkg;

    typedef enum logic [1:0] {
        BRC_IDLE,
        BRC_CMP,
        BRC_DONE
    } brc_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Non-branch funct3 encodings never take.
    function automatic logic taken(input logic [2:0] funct3, input logic less, input logic equal);
        case (funct3)
            F3_BEQ:           return equal;
            F3_BNE:           return !equal;
            F3_BLT, F3_BLTU:  return less;
            F3_BGE, F3_BGEU:  return !less;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/brc_slice_cmp.sv
// Combinational CHUNK-wide slice compare; is_top_signed flips the slice MSBs
// so the top slice orders as two's complement.
module brc_slice_cmp #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_top_signed,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] a_adj;
    logic [CHUNK-1:0] b_adj;

    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = is_top_signed;
        a_adj           = a ^ flip;
        b_adj           = b ^ flip;
        lt              = (a_adj < b_adj);
        eq              = (a == b);
    end

endmodule

// File: rtl/brc_seq.sv
// brc_seq: multi-cycle branch comparator, one CHUNK slice per cycle, MS slice first.
// Build option: BRC_SEQ_EARLY_EXIT_EN ends the compare on the first differing slice.
module brc_seq
    import brc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_br_un,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_br_less,
    output logic            o_br_equal,
    output logic            o_br_taken
);

    localparam int unsigned NCHUNK = XLEN / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

`ifdef BRC_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    brc_state_t      state;
    logic [IDXW-1:0] idx;
    logic            decided;
    logic            less_acc;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic            br_un_q;
    logic [2:0]      funct3_q;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic             top_signed;
    logic             slice_lt;
    logic             slice_eq;
    logic             cur_less;
    logic             cur_decided;
    logic             last_slice;

    assign o_ready = (state == BRC_IDLE);

    always_comb begin
        a_slice    = rs1_q[idx*CHUNK +: CHUNK];
        b_slice    = rs2_q[idx*CHUNK +: CHUNK];
        top_signed = !br_un_q && (idx == IDX_TOP);
    end

    brc_slice_cmp #(
        .CHUNK(CHUNK)
    ) u_slice_cmp (
        .a             (a_slice),
        .b             (b_slice),
        .is_top_signed (top_signed),
        .lt            (slice_lt),
        .eq            (slice_eq)
    );

    // An equal slice reports lt=0, so the undecided path needs no extra gating.
    always_comb begin
        cur_decided = decided || !slice_eq;
        cur_less    = decided ? less_acc : slice_lt;
        last_slice  = (idx == '0) || (EARLY_EXIT && !slice_eq);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= BRC_IDLE;
            idx        <= IDX_TOP;
            decided    <= 1'b0;
            less_acc   <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            br_un_q    <= 1'b0;
            funct3_q   <= '0;
            o_valid    <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_taken <= 1'b0;
        end else begin
            case (state)
                BRC_IDLE: begin
                    if (i_valid) begin
                        rs1_q    <= i_rs1_data;
                        rs2_q    <= i_rs2_data;
                        br_un_q  <= i_br_un;
                        funct3_q <= i_funct3;
                        idx      <= IDX_TOP;
                        decided  <= 1'b0;
                        less_acc <= 1'b0;
                        state    <= BRC_CMP;
                    end
                end
                BRC_CMP: begin
                    decided  <= cur_decided;
                    less_acc <= cur_less;
                    if (last_slice) begin
                        o_br_less  <= cur_less;
                        o_br_equal <= !cur_decided;
                        o_br_taken <= taken(funct3_q, cur_less, !cur_decided);
                        o_valid    <= 1'b1;
                        state      <= BRC_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                BRC_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= BRC_IDLE;
                    end
                end
                default: state <= BRC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brc_seq.sv
// Self-checking bench for brc_seq (XLEN=32, CHUNK=8); honours BRC_SEQ_EARLY_EXIT_EN for latency.
module tb_brc_seq;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    logic            i_br_un;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic            o_valid;
    logic            i_ready;
    logic            o_br_less;
    logic            o_br_equal;
    logic            o_br_taken;

    brc_seq #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_br_un    (i_br_un),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_less  (o_br_less),
        .o_br_equal (o_br_equal),
        .o_br_taken (o_br_taken)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        un;
        logic [2:0]  f3;
        logic        less;
        logic        eq;
        logic        tk;
    } vec_t;

    typedef struct {
        logic less;
        logic eq;
        logic tk;
        int   lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] f3, input logic l, input logic e);
        case (f3)
            3'b000:         return e;
            3'b001:         return !e;
            3'b100, 3'b110: return l;
            3'b101, 3'b111: return !l;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BRC_SEQ_EARLY_EXIT_EN
        for (int i = NCHUNK - 1; i >= 0; i--)
            if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) return NCHUNK - i;
        return NCHUNK;
`else
        return NCHUNK;
`endif
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one request through the accept edge, then scrambles the inputs.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic un,
                            input logic [2:0] f3, input logic el, input logic ee, input logic et);
        int   g = 0;
        exp_t e;
        while (!o_ready && g < 50) begin
            tick();
            g++;
        end
        chk("ready_before_accept", 64'(o_ready), 64'(1));
        i_valid    = 1'b1;
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        i_funct3   = f3;
        e.less = el;
        e.eq   = ee;
        e.tk   = et;
        e.lat  = model_lat(a, b);
        sb.push_back(e);
        tick();
        i_valid    = 1'b0;
        i_rs1_data = ~a;
        i_rs2_data = ~b;
        i_br_un    = ~un;
        i_funct3   = ~f3;
    endtask

    task automatic wait_check(input string tag);
        int   cyc = 0;
        exp_t e;
        while (!o_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
            chk({tag, "_less"},    64'(o_br_less),  64'(e.less));
            chk({tag, "_equal"},   64'(o_br_equal), 64'(e.eq));
            chk({tag, "_taken"},   64'(o_br_taken), 64'(e.tk));
        end
    endtask

    initial begin
        vec_t        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        un;
        logic        gl;
        logic        ge;
        logic [2:0]  f3;

        vecs[0]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 3'b110, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0001_0000, 32'h0000_FFFF, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h1234_5600, 32'h1234_5601, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 3'b101, 1'b0, 1'b1, 1'b1};

        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_br_un    = 1'b0;
        i_funct3   = '0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        #22;
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_less",  64'(o_br_less), 64'(0));
        chk("rst_equal", 64'(o_br_equal), 64'(0));
        chk("rst_taken", 64'(o_br_taken), 64'(0));
        tick();
        i_rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            v = vecs[i];
            start_op(v.a, v.b, v.un, v.f3, v.less, v.eq, v.tk);
            wait_check($sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d_idle_valid", i), 64'(o_valid), 64'(0));
            chk($sformatf("vec%0d_idle_ready", i), 64'(o_ready), 64'(1));
        end

        // Consumer stalls for 10 cycles while inputs churn.
        i_ready = 1'b0;
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1);
        wait_check("hold");
        for (int k = 0; k < 10; k++) begin
            i_rs1_data = $urandom;
            i_valid    = 1'b1;
            tick();
            chk("hold_valid", 64'(o_valid),   64'(1));
            chk("hold_ready", 64'(o_ready),   64'(0));
            chk("hold_less",  64'(o_br_less), 64'(1));
            chk("hold_equal", 64'(o_br_equal), 64'(0));
            chk("hold_taken", 64'(o_br_taken), 64'(1));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("hold_release_ready", 64'(o_ready), 64'(1));
        chk("hold_release_valid", 64'(o_valid), 64'(0));

        // Reset two cycles into CMP; only the low slice differs so early exit cannot finish first.
        start_op(32'h1122_3344, 32'h1122_3345, 1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        i_rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_ready", 64'(o_ready),    64'(1));
        chk("midrst_valid", 64'(o_valid),    64'(0));
        chk("midrst_less",  64'(o_br_less),  64'(0));
        chk("midrst_equal", 64'(o_br_equal), 64'(0));
        chk("midrst_taken", 64'(o_br_taken), 64'(0));
        tick();
        i_rst_n = 1'b1;
        for (int k = 0; k < NCHUNK + 2; k++) begin
            tick();
            chk("midrst_no_pulse", 64'(o_valid), 64'(0));
        end
        start_op(32'h0000_0005, 32'h0000_0007, 1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
        wait_check("post_rst");
        tick();

        for (int n = 0; n < 10000; n++) begin
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0)
                b = a ^ (32'($urandom_range(0, 255)) << (8 * $urandom_range(0, 3)));
            un = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            gl = un ? (a < b) : ($signed(a) < $signed(b));
            ge = (a == b);
            start_op(a, b, un, f3, gl, ge, model_taken(f3, gl, ge));
            wait_check("rand");
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
